seq_divider: RTL

- Sequential unsigned restoring divider. It is the inverse operation to the combinational multipliers in the arithmetic unit.
- Takes a WIDTH-bit dividend and divisor and produces quotient and remainder over WIDTH iterations, one per clock.
- Controlled by a start/done handshake.
- Sits beside the adder, subtractor and multiplier blocks as the ALU divide operation.

---
 rtl/seq_divider_pkg.sv | 11 +
 rtl/seq_divider_subtractor.sv | 25 ++
 rtl/seq_divider.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential arithmetic-unit operations.
package seq_divider_pkg;

    // Controller state encoding shared by sequential ALU ops.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_subtractor.sv
// Ripple-borrow full subtractor: diff_o = a_i - b_i, final_borrow_o set when a_i < b_i.
module seq_divider_subtractor #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             final_borrow_o
);

    logic [WIDTH:0] borrow;

    // Chain of single-bit full subtractor cells.
    always_comb begin
        borrow    = '0;
        diff_o    = '0;
        borrow[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow[i];
            borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
        end
        final_borrow_o = borrow[WIDTH];
    end

endmodule : seq_divider_subtractor

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// with a start/done handshake and divide-by-zero flagging.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    seq_state_e       state_q;
    logic [WIDTH-1:0] a_q;        // dividend shifts out the top, quotient fills the bottom
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   p_q;        // partial remainder
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;
    logic             trial_borrow;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] a_next;

    // Bring the next dividend bit into the partial remainder and restore on borrow.
    always_comb begin
        p_shift = (p_q << 1) | {{WIDTH{1'b0}}, a_q[WIDTH-1]};
        p_next  = trial_borrow ? p_shift : trial;
        a_next  = {a_q[WIDTH-2:0], ~trial_borrow};
    end

    seq_divider_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_trial_sub (
        .a_i            (p_shift),
        .b_i            ({1'b0, div_q}),
        .diff_o         (trial),
        .final_borrow_o (trial_borrow)
    );

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            div_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (in2 != '0) begin
                            a_q     <= in1;
                            div_q   <= in2;
                            p_q     <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end else begin
                            quotient_q  <= '1;
                            remainder_q <= in1;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StRun: begin
                    a_q   <= a_next;
                    p_q   <= p_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        quotient_q  <= a_next;
                        remainder_q <= p_next[WIDTH-1:0];
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // start is deliberately not looked at here
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : seq_divider
